// File: rtl/arith_pipe_unit_pkg.sv
// Shared definitions for the two-stage arithmetic pipeline: B-path mode
// encodings, the registered result-flag bundle and the overflow helper.
package arith_pipe_unit_pkg;

    // B-path operand modes applied ahead of each half adder
    typedef enum logic [1:0] {
        SEL_B    = 2'b00,
        SEL_NB   = 2'b01,
        SEL_ZERO = 2'b10,
        SEL_ONES = 2'b11
    } sel_e;

    // Flags registered alongside the result in the output stage
    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    // Two's-complement overflow: operands agree in sign, result does not
    function automatic logic signed_ovf(input logic a_msb, input logic y_msb,
                                        input logic r_msb);
        return (a_msb == y_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/arith_half_adder_stage.sv
// N-bit adder slice with B-operand mode mux; one instance per pipeline stage.
module arith_half_adder_stage
    import arith_pipe_unit_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  sel_e         sel,
    input  logic         cin,
    output logic [N-1:0] y,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Select the effective B operand
    always_comb begin
        y = b;
        unique case (sel)
            SEL_B:    y = b;
            SEL_NB:   y = ~b;
            SEL_ZERO: y = '0;
            SEL_ONES: y = '1;
            default:  y = b;
        endcase
    end

    // Widen by one bit so the carry falls out of the top
    assign {cout, sum} = {1'b0, a} + {1'b0, y} + {{N{1'b0}}, cin};

endmodule

// File: rtl/arith_pipe_unit.sv
// Two-stage pipelined adder with valid/ready handshakes, an accumulator fed
// from completed results and a saturating completed-operation counter.
// Stage 1 adds the low halves; stage 2 adds the high halves using the
// registered low carry and registers the result plus flags as outputs.
module arith_pipe_unit
    import arith_pipe_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_sel,
    input  logic             in_use_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned H = WIDTH / 2;

    // Stage 1 registers: low sum/carry and the untouched upper halves
    logic         s1_valid;
    logic [H-1:0] s1_lo_sum;
    logic         s1_lo_cout;
    logic [H-1:0] s1_a_hi;
    logic [H-1:0] s1_b_hi;
    sel_e         s1_sel;

    // Output stage flag register
    flags_t flags_q;

    // Handshake and flow-control terms
    logic out_hs;
    logic s2_load_ok;
    logic s1_adv;
    logic s1_load_ok;
    logic accept;

    // Operand selection
    logic [WIDTH-1:0] a_eff;
    sel_e             in_sel_e;

    // Adder slice results
    logic [H-1:0] lo_sum;
    logic         lo_cout;
    logic [H-1:0] lo_y_unused;
    logic [H-1:0] hi_sum;
    logic         hi_cout;
    logic [H-1:0] hi_y;
    flags_t       flags_d;

    assign in_sel_e = sel_e'(in_sel);

    // Flow control: a stage may load when empty or when it drains this cycle.
    // Accumulator-sourced requests wait for an empty pipe so they see the
    // latest accumulated value.
    always_comb begin
        out_hs     = out_valid & out_ready;
        s2_load_ok = ~out_valid | out_ready;
        s1_adv     = s1_valid & s2_load_ok;
        s1_load_ok = ~s1_valid | s1_adv;
        in_ready   = s1_load_ok & (~in_use_acc | (~s1_valid & ~out_valid));
        accept     = in_valid & in_ready;
    end

    // A operand source; a same-cycle clear makes the accumulator read as zero
    always_comb begin
        a_eff = in_a;
        if (in_use_acc) begin
            a_eff = acc_clr ? '0 : acc_q;
        end
    end

    arith_half_adder_stage #(
        .N (H)
    ) u_stage_lo (
        .a    (a_eff[H-1:0]),
        .b    (in_b[H-1:0]),
        .sel  (in_sel_e),
        .cin  (in_cin),
        .y    (lo_y_unused),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    arith_half_adder_stage #(
        .N (H)
    ) u_stage_hi (
        .a    (s1_a_hi),
        .b    (s1_b_hi),
        .sel  (s1_sel),
        .cin  (s1_lo_cout),
        .y    (hi_y),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    // Flags of the full-width result, evaluated in stage 2
    always_comb begin
        flags_d      = '0;
        flags_d.cout = hi_cout;
        flags_d.ovf  = signed_ovf(s1_a_hi[H-1], hi_y[H-1], hi_sum[H-1]);
        flags_d.zero = ({hi_sum, s1_lo_sum} == '0);
        flags_d.neg  = hi_sum[H-1];
    end

    // Stage 1: capture a new request or empty out as it moves on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_lo_sum  <= '0;
            s1_lo_cout <= 1'b0;
            s1_a_hi    <= '0;
            s1_b_hi    <= '0;
            s1_sel     <= SEL_B;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_lo_sum  <= lo_sum;
            s1_lo_cout <= lo_cout;
            s1_a_hi    <= a_eff[WIDTH-1:H];
            s1_b_hi    <= in_b[WIDTH-1:H];
            s1_sel     <= in_sel_e;
        end else if (s1_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    // Stage 2: result and flags only change on load, so they hold under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_d     <= '0;
            flags_q   <= '0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_d     <= {hi_sum, s1_lo_sum};
            flags_q   <= flags_d;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    assign out_cout = flags_q.cout;
    assign out_ovf  = flags_q.ovf;
    assign out_zero = flags_q.zero;
    assign out_neg  = flags_q.neg;

    // Accumulator tracks delivered results; clear takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (out_hs) begin
            acc_q <= out_d;
        end
    end

    // Completed-operation counter, sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_hs && (op_count != '1)) begin
            op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_arith_pipe_unit.sv
// Scoreboard bench for arith_pipe_unit (WIDTH=8). Expected results are queued
// at acceptance and compared when the DUT hands a result downstream.
module tb_arith_pipe_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [7:0] in_a, in_b;
    logic       in_cin;
    logic [1:0] in_sel;
    logic       in_use_acc, acc_clr;
    logic       out_valid, out_ready;
    logic [7:0] out_d;
    logic       out_cout, out_ovf, out_zero, out_neg;
    logic [7:0] acc_q;
    logic [15:0] op_count;

    // Second instance with a 2-bit counter shares all stimulus
    logic       d2_in_ready, d2_out_valid;
    logic [7:0] d2_out_d, d2_acc_q;
    logic       d2_cout, d2_ovf, d2_zero, d2_neg;
    logic [1:0] op_count2;

    always #5 clk = ~clk;

    arith_pipe_unit #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sel(in_sel),
        .in_use_acc(in_use_acc), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_d(out_d), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_neg(out_neg), .acc_q(acc_q), .op_count(op_count)
    );

    arith_pipe_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sel(in_sel),
        .in_use_acc(in_use_acc), .acc_clr(acc_clr), .out_valid(d2_out_valid),
        .out_ready(out_ready), .out_d(d2_out_d), .out_cout(d2_cout), .out_ovf(d2_ovf),
        .out_zero(d2_zero), .out_neg(d2_neg), .acc_q(d2_acc_q), .op_count(op_count2)
    );

    typedef struct {
        logic [7:0] d;
        logic       cout, ovf, zero, neg;
        int         acc_cyc;
        bit         chk_lat;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] model_acc = 8'h00;
    int         model_cnt = 0;
    bit         lat_flag = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic [3:0] prev_f;
    bit         rnd_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [1:0] sel, input logic cin);
        logic [7:0] y;
        logic [8:0] full;
        exp_t       e;
        case (sel)
            2'b00:   y = b;
            2'b01:   y = ~b;
            2'b10:   y = 8'h00;
            default: y = 8'hFF;
        endcase
        full      = {1'b0, a} + {1'b0, y} + {8'h00, cin};
        e.d       = full[7:0];
        e.cout    = full[8];
        e.ovf     = (a[7] == y[7]) && (full[7] != a[7]);
        e.zero    = (full[7:0] == 8'h00);
        e.neg     = full[7];
        e.acc_cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: per-cycle state checks, scoreboard push on accept, pop on output
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] a_use;
        if (rst_n) begin
            check_eq("acc_q", {24'h0, acc_q}, {24'h0, model_acc});
            check_eq("op_count", {16'h0, op_count}, model_cnt);
            check_eq("op_count_w2", {30'h0, op_count2}, (model_cnt > 3) ? 3 : model_cnt);
            if (prev_stall) begin
                check_eq("hold_d", {24'h0, out_d}, {24'h0, prev_d});
                check_eq("hold_flags", {28'h0, out_cout, out_ovf, out_zero, out_neg},
                         {28'h0, prev_f});
            end
            if (in_valid && in_ready) begin
                a_use     = in_use_acc ? (acc_clr ? 8'h00 : model_acc) : in_a;
                e         = model(a_use, in_b, in_sel, in_cin);
                e.acc_cyc = cyc;
                e.chk_lat = lat_flag;
                sb.push_back(e);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("out_d", {24'h0, out_d}, {24'h0, e.d});
                    check_eq("out_flags", {28'h0, out_cout, out_ovf, out_zero, out_neg},
                             {28'h0, e.cout, e.ovf, e.zero, e.neg});
                    if (e.chk_lat) check_eq("latency", cyc - e.acc_cyc, 2);
                    model_acc = e.d;
                    if (model_cnt < 65535) model_cnt++;
                end
            end
            if (acc_clr) model_acc = 8'h00;
            prev_stall = out_valid && !out_ready;
            prev_d     = out_d;
            prev_f     = {out_cout, out_ovf, out_zero, out_neg};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Present one request and hold it until accepted (bounded)
    task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                            input logic cin, input logic use_acc, input logic clr,
                            output int waits);
        in_valid   = 1'b1;
        in_a       = a;
        in_b       = b;
        in_sel     = sel;
        in_cin     = cin;
        in_use_acc = use_acc;
        acc_clr    = clr;
        waits      = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_use_acc = 1'b0;
        acc_clr    = 1'b0;
        in_a       = 8'hA5;
        in_b       = 8'h5A;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_done", (n < 100) ? 1 : 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, w3, cnt0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        in_sel = 2'b00; in_use_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'h0, out_valid}, 0);
        check_eq("rst_out_d", {24'h0, out_d}, 0);
        check_eq("rst_acc_q", {24'h0, acc_q}, 0);
        check_eq("rst_op_count", {16'h0, op_count}, 0);
        rst_n = 1'b1;

        // Basic adds with latency tracking, accepted right after reset release
        lat_flag = 1'b1;
        drive_op(8'h3C, 8'h05, 2'b00, 1'b0, 1'b0, 1'b0, w);
        check_eq("first_accept_wait", w, 0);
        drive_op(8'h7F, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0, w);
        drive_op(8'h05, 8'h05, 2'b01, 1'b1, 1'b0, 1'b0, w);
        check_eq("b2b_accept_wait", w, 0);
        drive_op(8'hFF, 8'h00, 2'b11, 1'b0, 1'b0, 1'b0, w);
        drain();
        lat_flag = 1'b0;

        // Backpressure: four back-to-back with out_ready low for three cycles
        cnt0 = model_cnt;
        out_ready = 1'b0;
        fork
            begin
                drive_op(8'h11, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0, w);
                drive_op(8'h22, 8'h02, 2'b00, 1'b0, 1'b0, 1'b0, w);
                check_eq("bp_second_wait", w, 0);
                drive_op(8'h33, 8'h03, 2'b00, 1'b0, 1'b0, 1'b0, w3);
                check_eq("bp_third_stalled", (w3 > 0) ? 1 : 0, 1);
                drive_op(8'h44, 8'h04, 2'b00, 1'b0, 1'b0, 1'b0, w);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check_eq("bp_count", {16'h0, op_count}, cnt0 + 4);

        // Accumulator chain: clear, load 0x10, then three +1 from accumulator
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        drive_op(8'h10, 8'h77, 2'b10, 1'b0, 1'b0, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            drive_op(8'hEE, 8'h77, 2'b10, 1'b1, 1'b1, 1'b0, w);
            check_eq("acc_hazard_stall", (w > 0) ? 1 : 0, 1);
        end
        drain();
        check_eq("acc_final", {24'h0, acc_q}, 32'h13);

        // Accumulator request accepted alongside a clear uses zero
        drive_op(8'h55, 8'h01, 2'b00, 1'b0, 1'b1, 1'b1, w);
        drain();
        check_eq("acc_clr_a_zero", {24'h0, acc_q}, 32'h01);

        // Clear coincident with an output handshake wins
        drive_op(8'h22, 8'h22, 2'b00, 1'b0, 1'b0, 1'b0, w);
        @(posedge clk);
        #1;
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        check_eq("clr_wins", {24'h0, acc_q}, 0);
        drain();

        // Random traffic with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    drive_op(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom),
                             ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), w);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with two operations in flight
        out_ready = 1'b0;
        drive_op(8'h01, 8'h02, 2'b00, 1'b0, 1'b0, 1'b0, w);
        drive_op(8'h03, 8'h04, 2'b00, 1'b0, 1'b0, 1'b0, w);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", {31'h0, out_valid}, 0);
        check_eq("mid_rst_acc_q", {24'h0, acc_q}, 0);
        check_eq("mid_rst_op_count", {16'h0, op_count}, 0);
        sb.delete();
        model_acc = 8'h00;
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("no_stale_result", {31'h0, out_valid}, 0);
        end
        @(posedge clk);
        #1;

        // Narrow counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive_op(8'(i), 8'h01, 2'b00, 1'b0, 1'b0, 1'b0, w);
        end
        drain();
        check_eq("cnt_w2_saturated", {30'h0, op_count2}, 3);
        check_eq("cnt_after_reset", {16'h0, op_count}, 5);
        check_eq("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
